// File: rtl/cmd_ctrl_pkg.sv
// Shared constants and types for the UART/button command controller.
// ASCII command codes, watch field encodings, FSM states and the command enum.
package cmd_ctrl_pkg;

  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_G     = 8'h47;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_D     = 8'h44;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;
  localparam logic [7:0] ASCII_2     = 8'h32;
  localparam logic [7:0] ASCII_3     = 8'h33;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  typedef enum logic [1:0] {IDLE, ECHO_REQ, ECHO_GUARD, ECHO_WAIT} state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_MODE, CMD_RUN, CMD_CLR, CMD_UP, CMD_DN, CMD_FIELD
  } cmd_t;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/cmd_decode.sv
// Combinational decoder for one received byte: command, field value,
// whether it acts in the current mode/field, and the echo byte to return.
module cmd_decode
  import cmd_ctrl_pkg::*;
(
  input  logic [7:0] rx_byte,
  input  logic       mode,
  input  logic [1:0] w_field,
  output cmd_t       cmd,
  output logic [1:0] field,
  output logic       acts,
  output logic [7:0] echo
);

  logic [7:0] upper_s;

  // Classify the case-folded byte and apply mode/field gating
  always_comb begin
    upper_s = to_upper(rx_byte);
    cmd     = CMD_NONE;
    field   = FIELD_NONE;
    acts    = 1'b0;
    case (upper_s)
      ASCII_M: begin cmd = CMD_MODE; acts = 1'b1;  end
      ASCII_G: begin cmd = CMD_RUN;  acts = ~mode; end
      ASCII_C: begin cmd = CMD_CLR;  acts = ~mode; end
      ASCII_U: begin cmd = CMD_UP;   acts = mode & (w_field != FIELD_NONE); end
      ASCII_D: begin cmd = CMD_DN;   acts = mode & (w_field != FIELD_NONE); end
      ASCII_0, ASCII_1, ASCII_2, ASCII_3: begin
        cmd   = CMD_FIELD;
        field = upper_s[1:0];
        acts  = mode;
      end
      default: begin cmd = CMD_NONE; acts = 1'b0; end
    endcase
    if (cmd == CMD_NONE) begin
      echo = ASCII_QMARK;
    end else if (acts) begin
      echo = upper_s;
    end else begin
      echo = ASCII_DASH;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Merges button pulses and UART commands into stopwatch/watch control pulses,
// owns mode and watch field, and echoes each UART command back to the transmitter.
module uart_cmd_ctrl
  import cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_btn_mode,
  input  logic       i_btn_runstop,
  input  logic       i_btn_clear,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_mode,
  output logic       o_sw_runstop,
  output logic       o_sw_clear,
  output logic [1:0] o_w_field,
  output logic       o_w_up,
  output logic       o_w_down,
  output logic       o_drop
);

  state_t     state_r, state_s;
  logic       pend_valid_r, pend_valid_s;
  logic [7:0] pend_byte_r, pend_byte_s;
  logic       mode_s, runstop_s, clear_s, up_s, down_s, tx_start_s, drop_s;
  logic [1:0] field_s;
  logic [7:0] tx_data_s;

  cmd_t       dec_cmd_s, exec_cmd_s;
  logic [1:0] dec_field_s, exec_field_s;
  logic       dec_acts_s, exec_acts_s, issue_s, field_set_s;
  logic [7:0] dec_echo_s;

  cmd_decode u_decode (
    .rx_byte (pend_byte_r),
    .mode    (o_mode),
    .w_field (o_w_field),
    .cmd     (dec_cmd_s),
    .field   (dec_field_s),
    .acts    (dec_acts_s),
    .echo    (dec_echo_s)
  );

  assign field_set_s = (o_w_field != FIELD_NONE);

  // Pick this cycle's command: buttons by priority, else the pending byte in IDLE
  always_comb begin
    exec_cmd_s   = CMD_NONE;
    exec_acts_s  = 1'b0;
    exec_field_s = FIELD_NONE;
    issue_s      = 1'b0;
    if (i_btn_clear) begin
      exec_cmd_s  = CMD_CLR;
      exec_acts_s = ~o_mode;
    end else if (i_btn_runstop) begin
      exec_cmd_s  = CMD_RUN;
      exec_acts_s = ~o_mode;
    end else if (i_btn_mode) begin
      exec_cmd_s  = CMD_MODE;
      exec_acts_s = 1'b1;
    end else if (i_btn_up) begin
      exec_cmd_s  = CMD_UP;
      exec_acts_s = o_mode & field_set_s;
    end else if (i_btn_down) begin
      exec_cmd_s  = CMD_DN;
      exec_acts_s = o_mode & field_set_s;
    end else if (state_r == IDLE && pend_valid_r) begin
      exec_cmd_s   = dec_cmd_s;
      exec_acts_s  = dec_acts_s;
      exec_field_s = dec_field_s;
      issue_s      = 1'b1;
    end else begin
      exec_cmd_s = CMD_NONE;
    end
  end

  // Next-state, pending register and output pulse computation
  always_comb begin
    state_s      = state_r;
    pend_valid_s = pend_valid_r;
    pend_byte_s  = pend_byte_r;
    mode_s       = o_mode;
    field_s      = o_w_field;
    runstop_s    = 1'b0;
    clear_s      = 1'b0;
    up_s         = 1'b0;
    down_s       = 1'b0;
    tx_start_s   = 1'b0;
    tx_data_s    = o_tx_data;
    drop_s       = 1'b0;

    if (exec_acts_s) begin
      case (exec_cmd_s)
        CMD_MODE:  begin mode_s = ~o_mode; field_s = FIELD_NONE; end
        CMD_RUN:   runstop_s = 1'b1;
        CMD_CLR:   clear_s   = 1'b1;
        CMD_UP:    up_s      = 1'b1;
        CMD_DN:    down_s    = 1'b1;
        CMD_FIELD: field_s   = exec_field_s;
        default:   mode_s    = o_mode;
      endcase
    end else begin
      mode_s = o_mode;
    end

    // The issue cycle frees the slot, so a byte arriving then is kept
    if (i_rx_done) begin
      if (!pend_valid_r || issue_s) begin
        pend_valid_s = 1'b1;
        pend_byte_s  = i_rx_data;
      end else begin
        drop_s = 1'b1;
      end
    end else if (issue_s) begin
      pend_valid_s = 1'b0;
    end else begin
      pend_valid_s = pend_valid_r;
    end

    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_s   = ECHO_REQ;
          tx_data_s = dec_echo_s;
        end else begin
          state_s = IDLE;
        end
      end
      ECHO_REQ: begin
        if (!i_tx_busy) begin
          tx_start_s = 1'b1;
          state_s    = ECHO_GUARD;
        end else begin
          state_s = ECHO_REQ;
        end
      end
      ECHO_GUARD: state_s = ECHO_WAIT;
      ECHO_WAIT: begin
        if (!i_tx_busy) begin
          state_s = IDLE;
        end else begin
          state_s = ECHO_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Register state and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pend_valid_r <= 1'b0;
      pend_byte_r  <= 8'h00;
      o_mode       <= 1'b0;
      o_w_field    <= FIELD_NONE;
      o_sw_runstop <= 1'b0;
      o_sw_clear   <= 1'b0;
      o_w_up       <= 1'b0;
      o_w_down     <= 1'b0;
      o_tx_start   <= 1'b0;
      o_tx_data    <= 8'h00;
      o_drop       <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_valid_r <= pend_valid_s;
      pend_byte_r  <= pend_byte_s;
      o_mode       <= mode_s;
      o_w_field    <= field_s;
      o_sw_runstop <= runstop_s;
      o_sw_clear   <= clear_s;
      o_w_up       <= up_s;
      o_w_down     <= down_s;
      o_tx_start   <= tx_start_s;
      o_tx_data    <= tx_data_s;
      o_drop       <= drop_s;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: command table, timing/corner sequences,
// and randomized buttons/bytes against a transaction-level reference model.
module tb_uart_cmd_ctrl;
  import cmd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done, tx_busy, tx_start;
  logic [7:0] tx_data;
  logic       btn_mode, btn_runstop, btn_clear, btn_up, btn_down;
  logic       mode, sw_runstop, sw_clear, w_up, w_down, drop;
  logic [1:0] w_field;

  int n_cmp = 0;
  int n_err = 0;
  int n_rs = 0, n_clr = 0, n_up = 0, n_dn = 0, n_drop = 0;
  logic [7:0] tx_q[$];

  // reference model state
  logic       m_mode;
  logic [1:0] m_field;
  int         e_rs, e_clr, e_up, e_dn;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] echo;
    logic [3:0] pulse;   // {runstop, clear, up, down}
    logic       mode;
    logic [1:0] field;
  } vec_t;
  vec_t vecs[25];

  always #5 clk = ~clk;

  uart_cmd_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_busy    (tx_busy),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_btn_mode   (btn_mode),
    .i_btn_runstop(btn_runstop),
    .i_btn_clear  (btn_clear),
    .i_btn_up     (btn_up),
    .i_btn_down   (btn_down),
    .o_mode       (mode),
    .o_sw_runstop (sw_runstop),
    .o_sw_clear   (sw_clear),
    .o_w_field    (w_field),
    .o_w_up       (w_up),
    .o_w_down     (w_down),
    .o_drop       (drop)
  );

  // monitor: count pulses and collect transmitted echo bytes
  always @(negedge clk) begin
    if (sw_runstop) n_rs   <= n_rs + 1;
    if (sw_clear)   n_clr  <= n_clr + 1;
    if (w_up)       n_up   <= n_up + 1;
    if (w_down)     n_dn   <= n_dn + 1;
    if (drop)       n_drop <= n_drop + 1;
    if (tx_start)   tx_q.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_uart(input logic [7:0] b, input bit rand_busy, output logic [7:0] echo);
    int  base;
    bit  seen;
    base    = tx_q.size();
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tx_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (tx_q.size() > base) seen = 1'b1;
    end
    tx_busy = 1'b0;
    repeat (4) tick();
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL echo_timeout: got no echo for byte 0x%0h, required one", b);
      echo = 8'h00;
    end else begin
      echo = tx_q[base];
    end
  endtask

  // spec rules applied to the model state; returns the echo the byte earns
  task automatic model_apply(input logic [7:0] c, output logic [7:0] echo);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (u == 8'h4D) begin
      m_mode = ~m_mode; m_field = 2'd0; echo = u;
    end else if (u == 8'h47 || u == 8'h43) begin
      if (!m_mode) begin
        if (u == 8'h47) e_rs++; else e_clr++;
        echo = u;
      end else echo = 8'h2D;
    end else if (u == 8'h55 || u == 8'h44) begin
      if (m_mode && m_field != 2'd0) begin
        if (u == 8'h55) e_up++; else e_dn++;
        echo = u;
      end else echo = 8'h2D;
    end else if (u >= 8'h30 && u <= 8'h33) begin
      if (m_mode) begin m_field = 2'(u - 8'h30); echo = u; end
      else echo = 8'h2D;
    end else begin
      echo = 8'h3F;
    end
  endtask

  initial begin
    logic [7:0] echo, m_echo;
    logic [7:0] chars [18];
    logic [4:0] btns;
    int b_rs, b_clr, b_up, b_dn, b_drop, base;

    vecs[0]  = '{8'h4D, 8'h4D, 4'h0, 1'b1, FIELD_NONE};
    vecs[1]  = '{8'h47, 8'h2D, 4'h0, 1'b1, FIELD_NONE};
    vecs[2]  = '{8'h4D, 8'h4D, 4'h0, 1'b0, FIELD_NONE};
    vecs[3]  = '{8'h47, 8'h47, 4'h8, 1'b0, FIELD_NONE};
    vecs[4]  = '{8'h6D, 8'h4D, 4'h0, 1'b1, FIELD_NONE};
    vecs[5]  = '{8'h33, 8'h33, 4'h0, 1'b1, FIELD_SEC};
    vecs[6]  = '{8'h55, 8'h55, 4'h2, 1'b1, FIELD_SEC};
    vecs[7]  = '{8'h55, 8'h55, 4'h2, 1'b1, FIELD_SEC};
    vecs[8]  = '{8'h64, 8'h44, 4'h1, 1'b1, FIELD_SEC};
    vecs[9]  = '{8'h4D, 8'h4D, 4'h0, 1'b0, FIELD_NONE};
    vecs[10] = '{8'h75, 8'h2D, 4'h0, 1'b0, FIELD_NONE};
    vecs[11] = '{8'h63, 8'h43, 4'h4, 1'b0, FIELD_NONE};
    vecs[12] = '{8'h5A, 8'h3F, 4'h0, 1'b0, FIELD_NONE};
    vecs[13] = '{8'h32, 8'h2D, 4'h0, 1'b0, FIELD_NONE};
    vecs[14] = '{8'h67, 8'h47, 4'h8, 1'b0, FIELD_NONE};
    vecs[15] = '{8'h4D, 8'h4D, 4'h0, 1'b1, FIELD_NONE};
    vecs[16] = '{8'h44, 8'h2D, 4'h0, 1'b1, FIELD_NONE};
    vecs[17] = '{8'h31, 8'h31, 4'h0, 1'b1, FIELD_HOUR};
    vecs[18] = '{8'h32, 8'h32, 4'h0, 1'b1, FIELD_MIN};
    vecs[19] = '{8'h30, 8'h30, 4'h0, 1'b1, FIELD_NONE};
    vecs[20] = '{8'h55, 8'h2D, 4'h0, 1'b1, FIELD_NONE};
    vecs[21] = '{8'h4D, 8'h4D, 4'h0, 1'b0, FIELD_NONE};
    vecs[22] = '{8'h2D, 8'h3F, 4'h0, 1'b0, FIELD_NONE};
    vecs[23] = '{8'h43, 8'h43, 4'h4, 1'b0, FIELD_NONE};
    vecs[24] = '{8'h35, 8'h3F, 4'h0, 1'b0, FIELD_NONE};

    chars = '{8'h4D, 8'h47, 8'h43, 8'h55, 8'h44, 8'h6D, 8'h67, 8'h63, 8'h75,
              8'h64, 8'h30, 8'h31, 8'h32, 8'h33, 8'h5A, 8'h3F, 8'h2D, 8'h78};

    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_busy = 1'b0;
    btn_mode = 1'b0; btn_runstop = 1'b0; btn_clear = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {tx_start, tx_data, mode, w_field, sw_runstop, sw_clear, w_up, w_down, drop}, 32'h0);
    reset = 1'b0;
    tick();

    // command table
    for (int i = 0; i < 25; i++) begin
      b_rs = n_rs; b_clr = n_clr; b_up = n_up; b_dn = n_dn;
      send_uart(vecs[i].rx, 1'b0, echo);
      check($sformatf("vec%0d_echo", i), echo, vecs[i].echo);
      check($sformatf("vec%0d_pulses", i),
            {4'(n_rs - b_rs), 4'(n_clr - b_clr), 4'(n_up - b_up), 4'(n_dn - b_dn)},
            {3'b000, vecs[i].pulse[3], 3'b000, vecs[i].pulse[2],
             3'b000, vecs[i].pulse[1], 3'b000, vecs[i].pulse[0]});
      check($sformatf("vec%0d_mode_field", i), {mode, w_field}, {vecs[i].mode, vecs[i].field});
    end

    // latency: 'C' at cycle 0 -> clear at 2, tx_start at 3
    rx_data = 8'h43; rx_done = 1'b1;
    tick(); rx_done = 1'b0;
    check("lat_c1_clear", sw_clear, 1'b0);
    tick();
    check("lat_c2_clear", {sw_clear, tx_start}, 2'b10);
    tick();
    check("lat_c3_tx", {sw_clear, tx_start, tx_data}, {2'b01, 8'h43});
    repeat (4) tick();

    // arbitration: buttons beat the pending byte, which goes one cycle later
    b_up = n_up; b_drop = n_drop;
    rx_data = 8'h47; rx_done = 1'b1;
    tick(); rx_done = 1'b0;
    btn_clear = 1'b1; btn_up = 1'b1;
    tick(); btn_clear = 1'b0; btn_up = 1'b0;
    check("arb_btn_clear", {sw_clear, sw_runstop}, 2'b10);
    tick();
    check("arb_g_issued", {sw_clear, sw_runstop}, 2'b01);
    tick();
    check("arb_g_echo", {tx_start, tx_data}, {1'b1, 8'h47});
    repeat (4) tick();
    check("arb_no_up_drop", {4'(n_up - b_up), 4'(n_drop - b_drop)}, 8'h00);

    // button mode toggle while an echo is queued
    tx_busy = 1'b1;
    rx_data = 8'h47; rx_done = 1'b1;
    tick(); rx_done = 1'b0;
    tick();
    btn_mode = 1'b1;
    tick(); btn_mode = 1'b0;
    check("midecho_mode", mode, 1'b1);
    tx_busy = 1'b0;
    tick();
    check("midecho_echo", {tx_start, tx_data}, {1'b1, 8'h47});
    repeat (4) tick();
    btn_mode = 1'b1; tick(); btn_mode = 1'b0; tick();
    check("btn_mode_back", mode, 1'b0);

    // overflow: third byte dropped while first echo is stalled
    b_rs = n_rs; b_clr = n_clr; b_drop = n_drop; base = tx_q.size();
    tx_busy = 1'b1;
    rx_data = 8'h43; rx_done = 1'b1; tick(); rx_done = 1'b0; tick(); tick();
    rx_data = 8'h4D; rx_done = 1'b1; tick(); rx_done = 1'b0; tick();
    rx_data = 8'h47; rx_done = 1'b1; tick(); rx_done = 1'b0;
    check("ovf_drop_pulse", drop, 1'b1);
    tick();
    check("ovf_drop_width", drop, 1'b0);
    tx_busy = 1'b0;
    for (int i = 0; i < 40 && tx_q.size() < base + 2; i++) tick();
    repeat (4) tick();
    check("ovf_echo_count", tx_q.size() - base, 2);
    if (tx_q.size() >= base + 2) begin
      check("ovf_echo_order", {tx_q[base], tx_q[base + 1]}, {8'h43, 8'h4D});
    end
    check("ovf_counts", {4'(n_drop - b_drop), 4'(n_clr - b_clr), 4'(n_rs - b_rs)}, 12'h110);
    check("ovf_mode", mode, 1'b1);
    btn_mode = 1'b1; tick(); btn_mode = 1'b0; tick();

    // unknown byte, then reset while the echo is stuck in ECHO_WAIT
    b_rs = n_rs; b_clr = n_clr; b_drop = n_drop;
    rx_data = 8'h5A; rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick(); tick();
    check("unk_echo", {tx_start, tx_data}, {1'b1, 8'h3F});
    tx_busy = 1'b1;
    tick(); tick();
    rx_data = 8'h4D; rx_done = 1'b1; tick(); rx_done = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_outputs", {tx_start, tx_data, mode, w_field, sw_runstop, sw_clear, w_up, w_down, drop}, 32'h0);
    tick();
    reset = 1'b0; tx_busy = 1'b0; base = tx_q.size();
    repeat (10) tick();
    check("rst_no_tx", tx_q.size() - base, 0);
    check("rst_pending_gone", {mode, 4'(n_drop - b_drop), 4'(n_clr - b_clr), 4'(n_rs - b_rs)}, 13'h0);

    // randomized buttons and bytes against the reference model
    m_mode = 1'b0; m_field = 2'd0; e_rs = 0; e_clr = 0; e_up = 0; e_dn = 0;
    b_rs = n_rs; b_clr = n_clr; b_up = n_up; b_dn = n_dn; b_drop = n_drop;
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        btns = 5'($urandom_range(1, 31));
        if (btns[4])      model_apply(8'h43, m_echo);
        else if (btns[3]) model_apply(8'h47, m_echo);
        else if (btns[2]) model_apply(8'h4D, m_echo);
        else if (btns[1]) model_apply(8'h55, m_echo);
        else              model_apply(8'h44, m_echo);
        {btn_clear, btn_runstop, btn_mode, btn_up, btn_down} = btns;
        tick();
        {btn_clear, btn_runstop, btn_mode, btn_up, btn_down} = 5'b00000;
        tick();
      end else begin
        logic [7:0] c;
        c = chars[$urandom_range(0, 17)];
        model_apply(c, m_echo);
        send_uart(c, 1'b1, echo);
        check($sformatf("rnd%0d_echo_%0h", s, c), echo, m_echo);
      end
      check($sformatf("rnd%0d_mode_field", s), {mode, w_field}, {m_mode, m_field});
    end
    check("rnd_pulse_counts",
          {8'(n_rs - b_rs), 8'(n_clr - b_clr), 8'(n_up - b_up), 8'(n_dn - b_dn)},
          {8'(e_rs), 8'(e_clr), 8'(e_up), 8'(e_dn)});
    check("rnd_no_drop", n_drop - b_drop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
